// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  Zero;
    logic                  mem_ready;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUControl;
    logic [2:0]            ImmSrc;
    logic                  illegal;
    logic                  instr_done;
    logic [DATA_WIDTH-1:0] instret;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instr_done, instret
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, instr_done, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle RV32I core: drives datapath enables/selects
// from the current state and counts retired instructions.
module multicycle_control #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_instret;

    logic       w_pc_write, w_adr_src, w_mem_write, w_ir_write, w_reg_write;
    logic       w_illegal, w_instr_done;
    logic [1:0] w_result_src, w_alu_src_a, w_alu_src_b;
    logic [2:0] w_alu_control, w_imm_src;

    function automatic logic [2:0] funct_decode(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  funct_decode = sub ? ALU_SUB : ALU_ADD;
            3'b010:  funct_decode = ALU_SLT;
            3'b100:  funct_decode = ALU_XOR;
            3'b110:  funct_decode = ALU_OR;
            3'b111:  funct_decode = ALU_AND;
            default: funct_decode = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_instr_done) r_instret <= r_instret + DATA_WIDTH'(1);
        end
    end

    // Next state and per-state datapath controls; unlisted signals stay 0.
    always_comb begin
        w_next        = r_state;
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_illegal     = 1'b0;
        w_instr_done  = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_alu_control = ALU_ADD;
        w_imm_src     = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_imm_src   = IMM_B;
                case (bus.op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b0110111:             w_next = S_LUI;
                    default:                w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = bus.op[5] ? IMM_S : IMM_I;
                w_next      = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = bus.mem_ready;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = funct_decode(bus.funct3, bus.op[5] & bus.funct7b5);
                w_next        = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = funct_decode(bus.funct3, 1'b0);
                w_next        = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                w_pc_write    = bus.Zero ^ bus.funct3[0];
                w_instr_done  = 1'b1;
                w_next        = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALUWB;
            end
            S_LUI: begin
                w_alu_src_a = 2'b11;
                w_alu_src_b = 2'b01;
                w_imm_src   = IMM_U;
                w_next      = S_ALUWB;
            end
            S_ILLEGAL: w_illegal = 1'b1;
            default:   w_next = S_FETCH;
        endcase
    end

    // Side-effecting strobes are suppressed while reset is held.
    assign bus.PCWrite    = w_pc_write   & ~rst;
    assign bus.IRWrite    = w_ir_write   & ~rst;
    assign bus.MemWrite   = w_mem_write  & ~rst;
    assign bus.RegWrite   = w_reg_write  & ~rst;
    assign bus.instr_done = w_instr_done & ~rst;
    assign bus.illegal    = w_illegal    & ~rst;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.instret    = r_instret;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction expectations are
// queued by the driver and checked by a monitor at each instr_done.
module tb_multicycle_control;
    localparam int unsigned DW = 32;

    localparam int K_LD = 0, K_ST = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;

    typedef struct {
        int         ncyc;
        int         npc;
        int         nrw;
        logic [1:0] rsrc;
        int         nmw;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [2:0] imm;
        int         instret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.DATA_WIDTH(DW)) bus();
    multicycle_control #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_ret = 0;
    bit   mon_en = 1'b0;
    exp_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU operation each funct3 should select.
    function automatic logic [2:0] alu_of(input logic [2:0] f3, input bit sub);
        case (f3)
            3'd0:    return sub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd4:    return 3'b100;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Build expectation, queue it, then drive the instruction for its predicted length.
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        exp_t       e;
        logic [6:0] opv;
        bit         mem;
        int         base;
        mem = (kind == K_LD) || (kind == K_ST);
        e.npc = 1; e.nrw = 1; e.rsrc = 2'b00; e.nmw = 0;
        e.a = 2'b10; e.b = 2'b01; e.alu = 3'b000; e.imm = 3'b000;
        case (kind)
            K_LD:  begin opv = 7'b0000011; base = 5; e.rsrc = 2'b01; end
            K_ST:  begin opv = 7'b0100011; base = 4; e.nrw = 0; e.nmw = 1 + mw; e.imm = 3'b001; end
            K_R:   begin opv = 7'b0110011; base = 4; e.b = 2'b00; e.alu = alu_of(f3, f7); end
            K_I:   begin opv = 7'b0010011; base = 4; e.alu = alu_of(f3, 1'b0); end
            K_BR:  begin
                opv = 7'b1100011; base = 3; e.nrw = 0; e.b = 2'b00; e.alu = 3'b001;
                e.npc = 1 + ((z != f3[0]) ? 1 : 0);
            end
            K_JAL: begin opv = 7'b1101111; base = 4; e.a = 2'b01; e.b = 2'b10; e.npc = 2; end
            default: begin opv = 7'b0110111; base = 4; e.a = 2'b11; e.imm = 3'b100; end
        endcase
        e.ncyc    = base + fw + (mem ? mw : 0);
        e.instret = model_ret;
        expq.push_back(e);
        model_ret++;
        for (int c = 0; c < e.ncyc; c++) begin
            bus.op = opv; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
            if (c < fw)                                   bus.mem_ready = 1'b0;
            else if (c == fw)                             bus.mem_ready = 1'b1;
            else if (mem && c >= fw + 3 && c < fw + 3 + mw) bus.mem_ready = 1'b0;
            else if (mem && c == fw + 3 + mw)             bus.mem_ready = 1'b1;
            else                                          bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Monitor: accumulate observed activity per instruction, compare at instr_done.
    int         m_cyc, m_ir, m_pc, m_rw, m_mw;
    logic [1:0] m_rsrc, m_a, m_b;
    logic [2:0] m_alu, m_imm;
    exp_t       m_e;

    task automatic mon_clear();
        m_cyc = 0; m_ir = -100; m_pc = 0; m_rw = 0; m_mw = 0;
        m_rsrc = 2'bxx; m_a = 2'bxx; m_b = 2'bxx; m_alu = 3'bxxx; m_imm = 3'bxxx;
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            mon_clear();
        end else begin
            m_cyc++;
            if (bus.IRWrite) m_ir = m_cyc;
            if (m_cyc == m_ir + 2) begin
                m_a = bus.ALUSrcA; m_b = bus.ALUSrcB; m_alu = bus.ALUControl; m_imm = bus.ImmSrc;
            end
            if (bus.PCWrite)  m_pc++;
            if (bus.MemWrite) m_mw++;
            if (bus.RegWrite) begin m_rw++; m_rsrc = bus.ResultSrc; end
            if (bus.instr_done) begin
                if (expq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got instr_done expected none at %0t", $time);
                end else begin
                    m_e = expq.pop_front();
                    check("cycles",    32'(m_cyc), 32'(m_e.ncyc));
                    check("pcwrites",  32'(m_pc),  32'(m_e.npc));
                    check("regwrites", 32'(m_rw),  32'(m_e.nrw));
                    check("memwrites", 32'(m_mw),  32'(m_e.nmw));
                    check("alusrca",   32'(m_a),   32'(m_e.a));
                    check("alusrcb",   32'(m_b),   32'(m_e.b));
                    check("aluctl",    32'(m_alu), 32'(m_e.alu));
                    check("immsrc",    32'(m_imm), 32'(m_e.imm));
                    check("instret",   bus.instret, 32'(m_e.instret));
                    if (m_e.nrw > 0) check("resultsrc", 32'(m_rsrc), 32'(m_e.rsrc));
                end
                mon_clear();
            end else if (m_cyc > 40) begin
                n_checks++; n_fail++;
                $display("FAIL timeout: got %0d cycles without instr_done expected at most 40", m_cyc);
                mon_clear();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        logic [2:0] f3;
        bus.op = 7'b0110011; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pcwrite",  32'(bus.PCWrite),    0);
        check("rst_irwrite",  32'(bus.IRWrite),    0);
        check("rst_memwrite", 32'(bus.MemWrite),   0);
        check("rst_regwrite", 32'(bus.RegWrite),   0);
        check("rst_done",     32'(bus.instr_done), 0);
        check("rst_illegal",  32'(bus.illegal),    0);
        check("rst_instret",  bus.instret,         0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_irwrite", 32'(bus.IRWrite), 1);
        check("post_rst_alusrcb", 32'(bus.ALUSrcB), 32'(2'b10));
        mon_en = 1'b1;

        run_instr(K_R,   3'd0, 1'b1, 1'b0, 0, 0);
        check("instret_after_sub", bus.instret, 1);
        run_instr(K_LD,  3'd2, 1'b0, 1'b0, 0, 2);
        run_instr(K_BR,  3'd0, 1'b0, 1'b1, 0, 0);
        run_instr(K_BR,  3'd1, 1'b0, 1'b1, 0, 0);
        run_instr(K_JAL, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(K_LUI, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(K_ST,  3'd2, 1'b0, 1'b0, 1, 2);
        run_instr(K_I,   3'd0, 1'b1, 1'b0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 6));
            f3   = 3'($urandom_range(0, 7));
            if (kind == K_BR) f3 = {2'b00, f3[0]};
            run_instr(kind, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        check("queue_drained", 32'(expq.size()), 0);
        check("instret_total", bus.instret, 32'(model_ret));

        // Unsupported opcode locks up until reset.
        mon_en = 1'b0;
        bus.op = 7'b1110011; bus.mem_ready = 1'b1;
        #1;
        check("illegal_c0", 32'(bus.illegal), 0);
        @(posedge clk); #1;
        check("illegal_c1", 32'(bus.illegal), 0);
        for (int c = 0; c < 6; c++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("illegal_set",  32'(bus.illegal),    1);
            check("illegal_done", 32'(bus.instr_done), 0);
            check("illegal_wen",  32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 0);
        end
        check("illegal_instret", bus.instret, 32'(model_ret));
        rst = 1'b1;
        #1;
        check("illegal_rst_gate", 32'(bus.illegal), 0);
        @(posedge clk); #1;
        rst = 1'b0; bus.op = 7'b0100011; bus.mem_ready = 1'b1;
        #1;
        check("illegal_cleared", 32'(bus.illegal), 0);
        check("fetch_after_rst", 32'(bus.IRWrite), 1);
        check("instret_cleared", bus.instret,      0);

        // Store interrupted by reset while waiting on memory.
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        #1;
        check("sw_wait_memwrite", 32'(bus.MemWrite), 1);
        rst = 1'b1;
        #1;
        check("sw_abort_memwrite", 32'(bus.MemWrite),   0);
        check("sw_abort_done",     32'(bus.instr_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_ret = 0;
        mon_en = 1'b1;
        run_instr(K_LUI, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr(K_R,   3'd7, 1'b0, 1'b0, 2, 0);
        check("final_instret", bus.instret, 32'(model_ret));
        check("final_queue",   32'(expq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
